// File: rtl/controlador_gravacao_hd_if.sv
// Signal bundle between the HD save controller and its environment
// (control unit, data memory read port, HD write port, debug state).
interface controlador_gravacao_hd_if #(
  parameter int ADDR_W = 12
);
  logic              Store_to_HD;
  logic [ADDR_W-1:0] indice_programa;
  logic [ADDR_W-1:0] mem_endereco;
  logic [31:0]       mem_dado;
  logic [ADDR_W-1:0] hd_endereco;
  logic [31:0]       hd_dado;
  logic              hd_write;
  logic              hd_ready;
  logic              gravando;
  logic              concluido;
  logic [2:0]        estado;

  // HD handshake: the controller raises hd_write with hd_endereco/hd_dado and
  // holds all three stable; the word is accepted on the rising edge where
  // hd_write=1 and hd_ready=1. hd_ready has no meaning while hd_write=0.
  modport master (
    input  Store_to_HD, indice_programa, mem_dado, hd_ready,
    output mem_endereco, hd_endereco, hd_dado, hd_write, gravando, concluido, estado
  );

  modport slave (
    output Store_to_HD, indice_programa, mem_dado, hd_ready,
    input  mem_endereco, hd_endereco, hd_dado, hd_write, gravando, concluido, estado
  );
endinterface

// File: rtl/controlador_gravacao_hd.sv
// Copies one block of BLOCK_WORDS data-memory words (addresses 0..N-1) to the
// HD at indice_programa*BLOCK_WORDS, one word per READ/WAIT/WRITE round.
module controlador_gravacao_hd #(
  parameter int BLOCK_WORDS = 256,
  parameter int ADDR_W      = 12
) (
  input logic                   Clock,
  input logic                   Reset,
  controlador_gravacao_hd_if.master bus
);
  localparam int                SHIFT = $clog2(BLOCK_WORDS);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(BLOCK_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WAIT  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t            state;
  logic              store_s1;
  logic              store_s2;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] counter;
  logic [31:0]       data_q;
  logic [ADDR_W-1:0] hd_addr_q;
  logic              hd_write_q;
  logic              gravando_q;
  logic              concluido_q;
  logic              start;

  // Edge detect runs on registered samples so a held level fires only once.
  assign start = store_s1 && !store_s2;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state       <= IDLE;
      store_s1    <= 1'b0;
      store_s2    <= 1'b0;
      base        <= '0;
      counter     <= '0;
      data_q      <= '0;
      hd_addr_q   <= '0;
      hd_write_q  <= 1'b0;
      gravando_q  <= 1'b0;
      concluido_q <= 1'b0;
    end else begin
      store_s1 <= bus.Store_to_HD;
      store_s2 <= store_s1;
      case (state)
        IDLE: begin
          if (start) begin
            base       <= bus.indice_programa << SHIFT;
            counter    <= '0;
            gravando_q <= 1'b1;
            state      <= READ;
          end
        end
        READ: state <= WAIT;
        WAIT: begin
          data_q     <= bus.mem_dado;
          hd_addr_q  <= base + counter;
          hd_write_q <= 1'b1;
          state      <= WRITE;
        end
        WRITE: begin
          if (bus.hd_ready) begin
            hd_write_q <= 1'b0;
            if (counter == LAST) begin
              gravando_q  <= 1'b0;
              concluido_q <= 1'b1;
              state       <= DONE;
            end else begin
              counter <= counter + ADDR_W'(1);
              state   <= READ;
            end
          end
        end
        DONE: begin
          concluido_q <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_endereco = counter;
  assign bus.hd_endereco  = hd_addr_q;
  assign bus.hd_dado      = data_q;
  assign bus.hd_write     = hd_write_q;
  assign bus.gravando     = gravando_q;
  assign bus.concluido    = concluido_q;
  assign bus.estado       = state;
endmodule

// File: tb/tb_controlador_gravacao_hd.sv
// Directed bench for controlador_gravacao_hd with BLOCK_WORDS=4, ADDR_W=12 and
// a data memory that returns 0xA0+address one cycle after the address.
module tb_controlador_gravacao_hd;
  localparam int BW = 4;
  localparam int AW = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;

  controlador_gravacao_hd_if #(.ADDR_W(AW)) bus ();

  controlador_gravacao_hd #(.BLOCK_WORDS(BW), .ADDR_W(AW)) dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) bus.mem_dado <= 32'hA0 + {20'b0, bus.mem_endereco};

  int tests_run    = 0;
  int tests_failed = 0;
  int done_cnt     = 0;
  int grav_cnt     = 0;
  int wr_cyc       = 0;
  int hold_cnt     = 0;
  logic [43:0] act_q[$];
  logic [43:0] exp_q[$];

  always @(negedge clk) begin
    if (bus.hd_write && bus.hd_ready) act_q.push_back({bus.hd_endereco, bus.hd_dado});
    if (bus.hd_write) wr_cyc++;
    if (bus.hd_write && bus.hd_endereco == 12'd8 && bus.hd_dado == 32'hA0) hold_cnt++;
    if (bus.concluido) done_cnt++;
    if (bus.gravando) grav_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    act_q.delete();
    exp_q.delete();
    done_cnt = 0;
    grav_cnt = 0;
    wr_cyc   = 0;
    hold_cnt = 0;
  endtask

  // Called just after a rising edge; returns just after the start-sampling edge.
  task automatic kick(input logic [AW-1:0] idx);
    bus.indice_programa = idx;
    bus.Store_to_HD     = 1'b1;
    @(posedge clk);
    #1 bus.Store_to_HD = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    bit found = 1'b0;
    cyc = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.concluido) begin
        found = 1'b1;
        break;
      end
      @(posedge clk);
      cyc++;
    end
    check("done_seen", 32'(found), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic check_writes(input string tag, input logic [AW-1:0] base, input int n);
    logic [AW-1:0] a;
    logic [43:0]   e;
    logic [43:0]   g;
    for (int k = 0; k < n; k++) begin
      a = base + AW'(k);
      exp_q.push_back({a, 32'hA0 + 32'(k)});
    end
    check({tag, "_count"}, 32'(act_q.size()), 32'(n));
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      e = exp_q.pop_front();
      g = act_q.pop_front();
      check({tag, "_addr"}, {20'b0, g[43:32]}, {20'b0, e[43:32]});
      check({tag, "_data"}, g[31:0], e[31:0]);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_hd_write"},  {31'b0, bus.hd_write},  32'd0);
    check({tag, "_gravando"},  {31'b0, bus.gravando},  32'd0);
    check({tag, "_concluido"}, {31'b0, bus.concluido}, 32'd0);
    check({tag, "_mem_end"},   {20'b0, bus.mem_endereco}, 32'd0);
    check({tag, "_hd_end"},    {20'b0, bus.hd_endereco},  32'd0);
    check({tag, "_hd_dado"},   bus.hd_dado, 32'd0);
    check({tag, "_estado"},    {29'b0, bus.estado}, 32'd0);
  endtask

  initial begin
    int  cyc;
    bit  seen;
    bus.Store_to_HD     = 1'b0;
    bus.indice_programa = '0;
    bus.hd_ready        = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk);
    #1;

    // Basic save of block 2.
    clear_logs();
    kick(12'd2);
    wait_done(cyc);
    check("t1_latency", 32'(cyc), 32'd13);
    repeat (3) @(posedge clk);
    #1;
    check("t1_gravando_cycles", 32'(grav_cnt), 32'd12);
    check("t1_done_pulses", 32'(done_cnt), 32'd1);
    check_writes("t1", 12'd8, 4);

    // HD stalls the first word for 5 cycles.
    clear_logs();
    bus.hd_ready = 1'b0;
    kick(12'd2);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.hd_write) begin
        seen = 1'b1;
        break;
      end
    end
    check("t2_write_seen", 32'(seen), 32'd1);
    repeat (5) @(posedge clk);
    #1 bus.hd_ready = 1'b1;
    wait_done(cyc);
    repeat (3) @(posedge clk);
    #1;
    check("t2_hold_cycles", 32'(hold_cnt), 32'd6);
    check("t2_write_cycles", 32'(wr_cyc), 32'd9);
    check_writes("t2", 12'd8, 4);

    // Level held high for 40 cycles triggers a single save.
    clear_logs();
    bus.indice_programa = 12'd2;
    bus.Store_to_HD     = 1'b1;
    repeat (40) @(posedge clk);
    #1 bus.Store_to_HD = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("t3_done_pulses", 32'(done_cnt), 32'd1);
    check_writes("t3", 12'd8, 4);

    // Second edge and indice change during a save are ignored.
    clear_logs();
    kick(12'd2);
    repeat (4) @(posedge clk);
    #1 bus.Store_to_HD = 1'b1;
    bus.indice_programa = 12'd5;
    repeat (2) @(posedge clk);
    #1 bus.Store_to_HD = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("t4_done_pulses", 32'(done_cnt), 32'd1);
    check_writes("t4", 12'd8, 4);

    // Top block and wrap past the end of the HD address space.
    clear_logs();
    kick(12'd1023);
    wait_done(cyc);
    repeat (2) @(posedge clk);
    #1;
    check_writes("t5_top", 12'd4092, 4);
    clear_logs();
    kick(12'd1024);
    wait_done(cyc);
    repeat (2) @(posedge clk);
    #1;
    check_writes("t5_wrap", 12'd0, 4);

    // Reset in WAIT of word 2 aborts the save.
    clear_logs();
    kick(12'd2);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.estado == 3'd2 && bus.mem_endereco == 12'd2) begin
        seen = 1'b1;
        break;
      end
    end
    check("t6_wait2_seen", 32'(seen), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("t6_after_reset");
    repeat (10) @(posedge clk);
    #1;
    check("t6_done_pulses", 32'(done_cnt), 32'd0);
    check_writes("t6_abort", 12'd8, 2);
    clear_logs();
    kick(12'd2);
    wait_done(cyc);
    repeat (2) @(posedge clk);
    #1;
    check("t6_restart_latency", 32'(cyc), 32'd13);
    check_writes("t6_restart", 12'd8, 4);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
